// File: rtl/tracker_pkg.sv
// Package: tracker_pkg
// Shared types and default sizes for core_run_tracker and its FSM.
//   trk_state_t      : tracker state encoding (IDLE, RUN, DONE, TOUT), 2 bits
//   DEF_CYCLE_CNT_W  : default width of the cycle counter datapath
//   DEF_TIMEOUT_CYC  : default watchdog limit in cycles
package tracker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    TOUT = 2'd3
  } trk_state_t;

  localparam int DEF_CYCLE_CNT_W = 32;
  localparam int DEF_TIMEOUT_CYC = 5000;

endpackage

// File: rtl/core_run_tracker_fsm.sv
// Module: core_run_tracker_fsm
// Control FSM of the run tracker. It decides the next state from the
// trigger, the end-of-test flag and the watchdog compare, and holds the
// state register.
// Ports:
//   clk         in  rising-edge clock
//   rst         in  synchronous active-high reset, overrides enable
//   enable      in  state register updates only when 1
//   trigger     in  CPU-go pulse, starts a run from IDLE/DONE/TOUT
//   test_undone in  0 = test finished; examined only in RUN
//   timeout_hit in  watchdog limit reached this cycle (0 when disabled)
//   state       out current state (also serves as the debug view)
//   state_next  out state that will be loaded on the next enabled edge
import tracker_pkg::*;

module core_run_tracker_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       trigger,
  input  logic       test_undone,
  input  logic       timeout_hit,
  output trk_state_t state,
  output trk_state_t state_next
);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, TOUT: begin
        if (trigger) state_next = RUN;
      end
      RUN: begin
        // Completion is checked first so it wins over a same-cycle timeout.
        if (!test_undone)     state_next = DONE;
        else if (timeout_hit) state_next = TOUT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         state <= IDLE;
    else if (enable) state <= state_next;
  end

endmodule

// File: rtl/core_run_tracker.sv
// Module: core_run_tracker
// Test-run tracker: stamps cycle_count when the CPU-go trigger fires,
// follows the run until test_undone drops and reports the elapsed cycles,
// a one-cycle done pulse and a saturating count of completed runs.
// Optional watchdog: define TRACKER_TIMEOUT_EN to end a run that lasts
// TIMEOUT_CYC cycles with the sticky timeout flag instead of done.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   enable       clock-enable; every register holds when 0
//   trigger      CPU-go pulse
//   test_undone  1 while the test executes
//   cycle_count  free-running cycle counter
//   running      1 while in RUN
//   done         one-cycle pulse on normal completion
//   start_stamp  cycle_count captured at trigger
//   elapsed      live run length in RUN, frozen afterwards
//   run_count    completed runs, saturating
//   timeout      sticky watchdog flag, cleared by the next trigger
import tracker_pkg::*;

module core_run_tracker #(
  parameter int CYCLE_CNT_W = DEF_CYCLE_CNT_W,
  parameter int RUN_CNT_W   = 8,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   trigger,
  input  logic                   test_undone,
  input  logic [CYCLE_CNT_W-1:0] cycle_count,
  output logic                   running,
  output logic                   done,
  output logic [CYCLE_CNT_W-1:0] start_stamp,
  output logic [CYCLE_CNT_W-1:0] elapsed,
  output logic [RUN_CNT_W-1:0]   run_count,
  output logic                   timeout
);

  trk_state_t             state;
  trk_state_t             state_next;
  logic [CYCLE_CNT_W-1:0] run_len;
  logic                   timeout_hit;
  logic                   start_run;
  logic                   complete;
  logic                   tout_enter;

  // Modulo subtraction keeps the length right across counter wrap-around.
  assign run_len = cycle_count - start_stamp;

`ifdef TRACKER_TIMEOUT_EN
  assign timeout_hit = (run_len >= CYCLE_CNT_W'(TIMEOUT_CYC));
`else
  assign timeout_hit = 1'b0;
`endif

  core_run_tracker_fsm u_fsm (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .trigger     (trigger),
    .test_undone (test_undone),
    .timeout_hit (timeout_hit),
    .state       (state),
    .state_next  (state_next)
  );

  // Datapath actions are decoded from the FSM transition so the control
  // decision lives in one place.
  assign start_run  = (state != RUN) && (state_next == RUN);
  assign complete   = (state == RUN) && (state_next == DONE);
  assign tout_enter = (state == RUN) && (state_next == TOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      running     <= 1'b0;
      done        <= 1'b0;
      start_stamp <= '0;
      elapsed     <= '0;
      run_count   <= '0;
    end else if (enable) begin
      running <= (state_next == RUN);
      done    <= complete;
      if (start_run) begin
        start_stamp <= cycle_count;
        elapsed     <= '0;
      end else if (state == RUN) begin
        // Covers the live update, completion and timeout latch alike.
        elapsed <= run_len;
      end
      if (complete && (run_count != {RUN_CNT_W{1'b1}}))
        run_count <= run_count + 1'b1;
    end
  end

`ifdef TRACKER_TIMEOUT_EN
  logic timeout_q;

  always_ff @(posedge clk) begin
    if (rst)                          timeout_q <= 1'b0;
    else if (enable && start_run)     timeout_q <= 1'b0;
    else if (enable && tout_enter)    timeout_q <= 1'b1;
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_core_run_tracker.sv
// Bench for core_run_tracker: a table of per-cycle vectors for reset and
// basic runs, followed by hand-written sequences for wrap-around, enable
// gating, the watchdog and reset in the middle of a run.
module tb_core_run_tracker;

`ifdef TRACKER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        trigger;
  logic        test_undone;
  logic [31:0] cycle_count;
  logic        running;
  logic        done;
  logic [31:0] start_stamp;
  logic [31:0] elapsed;
  logic [7:0]  run_count;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  core_run_tracker #(
    .CYCLE_CNT_W (32),
    .RUN_CNT_W   (8),
    .TIMEOUT_CYC (200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .trigger     (trigger),
    .test_undone (test_undone),
    .cycle_count (cycle_count),
    .running     (running),
    .done        (done),
    .start_stamp (start_stamp),
    .elapsed     (elapsed),
    .run_count   (run_count),
    .timeout     (timeout)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        trig;
    logic        und;
    logic [31:0] cc;
    logic        run;
    logic        dn;
    logic [31:0] stamp;
    logic [31:0] el;
    logic [7:0]  rc;
    logic        tmo;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s actual=%0h expected=%0h", tag, what, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic e_run, input logic e_dn,
                           input logic [31:0] e_stamp, input logic [31:0] e_el,
                           input logic [7:0] e_rc, input logic e_tmo);
    check(tag, "running",     {31'd0, running}, {31'd0, e_run});
    check(tag, "done",        {31'd0, done},    {31'd0, e_dn});
    check(tag, "start_stamp", start_stamp,      e_stamp);
    check(tag, "elapsed",     elapsed,          e_el);
    check(tag, "run_count",   {24'd0, run_count}, {24'd0, e_rc});
    check(tag, "timeout",     {31'd0, timeout}, {31'd0, e_tmo});
  endtask

  // driver: present inputs for one clock edge, then sample 1 time unit later
  task automatic drive(input logic r, input logic e, input logic t,
                       input logic u, input logic [31:0] c);
    rst         = r;
    enable      = e;
    trigger     = t;
    test_undone = u;
    cycle_count = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; trigger = 1'b0; test_undone = 1'b1; cycle_count = '0;

    //          rst en trg und cc      run dn stamp el  rc tmo
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd0,   1'b0, 1'b0, 32'd0,   32'd0,  8'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd1,   1'b0, 1'b0, 32'd0,   32'd0,  8'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd2,   1'b0, 1'b0, 32'd0,   32'd0,  8'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd10,  1'b1, 1'b0, 32'd10,  32'd0,  8'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd11,  1'b1, 1'b0, 32'd10,  32'd1,  8'd0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd30,  1'b1, 1'b0, 32'd10,  32'd20, 8'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd57,  1'b0, 1'b1, 32'd10,  32'd47, 8'd1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd58,  1'b0, 1'b0, 32'd10,  32'd47, 8'd1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd100, 1'b1, 1'b0, 32'd100, 32'd0,  8'd1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd101, 1'b0, 1'b1, 32'd100, 32'd1,  8'd2, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd102, 1'b0, 1'b0, 32'd100, 32'd1,  8'd2, 1'b0};

    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].trig, vecs[i].und, vecs[i].cc);
      check_out($sformatf("vec%0d", i), vecs[i].run, vecs[i].dn, vecs[i].stamp,
                vecs[i].el, vecs[i].rc, vecs[i].tmo);
    end

    // wrap-around of the cycle counter
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF0);
    check_out("wrap_start", 1'b1, 1'b0, 32'hFFFF_FFF0, 32'd0, 8'd2, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    check_out("wrap_mid", 1'b1, 1'b0, 32'hFFFF_FFF0, 32'd8, 8'd2, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0010);
    check_out("wrap_done", 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h20, 8'd3, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0011);
    check_out("wrap_hold", 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h20, 8'd3, 1'b0);

    // enable gating mid-run with trigger and test_undone=0 pulsed
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd200);
    check_out("gate_start", 1'b1, 1'b0, 32'd200, 32'd0, 8'd3, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd205);
    check_out("gate_pre", 1'b1, 1'b0, 32'd200, 32'd5, 8'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, (i % 2) == 0, (i % 2) == 1, 32'd206 + 32'(i));
      check_out($sformatf("gate_off%0d", i), 1'b1, 1'b0, 32'd200, 32'd5, 8'd3, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd211);
    check_out("gate_resume", 1'b1, 1'b0, 32'd200, 32'd11, 8'd3, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd212);
    check_out("gate_done", 1'b0, 1'b1, 32'd200, 32'd12, 8'd4, 1'b0);

    // watchdog (TIMEOUT_CYC = 200)
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd1000);
    check_out("tmo_start", 1'b1, 1'b0, 32'd1000, 32'd0, 8'd4, 1'b0);
    for (int c = 1001; c <= 1300; c++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'(c));
      if (c == 1199)
        check_out("tmo_before", 1'b1, 1'b0, 32'd1000, 32'd199, 8'd4, 1'b0);
      if (c == 1200)
        check_out("tmo_at", !TMO_EN, 1'b0, 32'd1000, 32'd200, 8'd4, TMO_EN);
      if (c == 1300)
        check_out("tmo_later", !TMO_EN, 1'b0, 32'd1000, TMO_EN ? 32'd200 : 32'd300,
                  8'd4, TMO_EN);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd1301);
    check_out("tmo_undone", 1'b0, !TMO_EN, 32'd1000, TMO_EN ? 32'd200 : 32'd301,
              TMO_EN ? 8'd4 : 8'd5, TMO_EN);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd1400);
    check_out("tmo_retrig", 1'b1, 1'b0, 32'd1400, 32'd0, TMO_EN ? 8'd4 : 8'd5, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd1405);
    check_out("tmo_rerun", 1'b0, 1'b1, 32'd1400, 32'd5, TMO_EN ? 8'd5 : 8'd6, 1'b0);

    // reset in the middle of a run
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd2000);
    check_out("rst_start", 1'b1, 1'b0, 32'd2000, 32'd0, TMO_EN ? 8'd5 : 8'd6, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'd2001);
    check_out("rst_mid", 1'b1, 1'b0, 32'd2000, 32'd1, TMO_EN ? 8'd5 : 8'd6, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'd2002);
    check_out("rst_hit", 1'b0, 1'b0, 32'd0, 32'd0, 8'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd2010);
    check_out("rst_retrig", 1'b1, 1'b0, 32'd2010, 32'd0, 8'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd2015);
    check_out("rst_rerun", 1'b0, 1'b1, 32'd2010, 32'd5, 8'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
